// File: rtl/rv32i_icache.sv
// ---------------------------------------------------------------------------
// rv32i_icache
//   Direct-mapped, read-only instruction cache between the RV32i fetch port
//   and a word-wide instruction memory.
//   A hit returns data in the same cycle. A miss starts a refill of the whole
//   line, one word per memory handshake, and keeps imem_valid_o low until the
//   refill is done. Fetch is stalled for that time.
//   flush_i (fence.i) invalidates every line. Saturating counters record hit
//   cycles and refills started.
//
// Ports
//   clk_i, resetn_i             clock (rising edge), async active-low reset
//   imem_add_i                  fetch byte address (bits [1:0] ignored)
//   imem_data_o / imem_valid_o  fetched word / hit this cycle
//   flush_i                     invalidate all lines (1-cycle pulse)
//   mem_req_o / mem_add_o       refill word request and its byte address
//   mem_ack_i / mem_data_i      refill word returned this cycle
//   hit_cnt_o / miss_cnt_o      hit cycles / refills started (saturating)
// ---------------------------------------------------------------------------
module rv32i_icache #(
  parameter int NB_LINES   = 16,
  parameter int LINE_WORDS = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic [31:0]      imem_add_i,
  output logic [31:0]      imem_data_o,
  output logic             imem_valid_o,
  input  logic             flush_i,
  output logic             mem_req_o,
  output logic [31:0]      mem_add_o,
  input  logic             mem_ack_i,
  input  logic [31:0]      mem_data_i,
  output logic [CNT_W-1:0] hit_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o
);

  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = WORD_W + 2;
  localparam int IDX_W  = $clog2(NB_LINES);
  localparam int TAG_W  = 32 - IDX_W - OFF_W;
  localparam int LINE_W = 32 - OFF_W;           // line address = {tag, idx}

  typedef enum logic {
    S_IDLE,
    S_REFILL
  } state_e;

  // Lookup fields of the fetch address.
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag_in;
  logic [WORD_W-1:0] word_sel;
  logic              unused_addr_bits;

  assign idx              = imem_add_i[OFF_W +: IDX_W];
  assign tag_in           = imem_add_i[31 -: TAG_W];
  assign word_sel         = imem_add_i[OFF_W-1:2];
  assign unused_addr_bits = ^imem_add_i[1:0];

  // Tag and data storage.
  logic [TAG_W-1:0] tag_mem  [NB_LINES];
  logic [31:0]      data_mem [NB_LINES*LINE_WORDS];

  // Control state.
  state_e             state_q, state_d;
  logic [NB_LINES-1:0] valid_q, valid_d;
  logic [LINE_W-1:0]  line_q, line_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic               flush_pend_q, flush_pend_d;
  logic               req_q, req_d;
  logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

  // Refill target, taken from the latched line address.
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic             last_word;
  logic             data_we;
  logic             tag_we;
  logic             hit;

  assign fill_idx  = line_q[IDX_W-1:0];
  assign fill_tag  = line_q[IDX_W +: TAG_W];
  assign last_word = (word_q == WORD_W'(LINE_WORDS - 1));

  // req_q is always high in S_REFILL, so an ack there is a real handshake.
  // Acks seen in S_IDLE are dropped.
  assign data_we = (state_q == S_REFILL) && mem_ack_i;
  assign tag_we  = data_we && last_word;

  // An invalid line's tag may be uninitialised. The valid bit gates it out.
  assign hit          = valid_q[idx] && (tag_mem[idx] == tag_in);
  assign imem_valid_o = hit && (state_q == S_IDLE) && !flush_i;
  assign imem_data_o  = imem_valid_o ? data_mem[{idx, word_sel}] : 32'h0;

  assign mem_req_o  = req_q;
  assign mem_add_o  = {line_q, word_q, 2'b00};
  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;

  // Next-state logic.
  // NOTE: every _d gets its _q value first, so paths that do not assign it
  // hold state instead of inferring a latch.
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    line_d       = line_q;
    word_d       = word_q;
    flush_pend_d = flush_pend_q;
    req_d        = req_q;
    hit_cnt_d    = hit_cnt_q;
    miss_cnt_d   = miss_cnt_q;

    if (imem_valid_o && (hit_cnt_q != {CNT_W{1'b1}})) begin
      hit_cnt_d = hit_cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (flush_i) begin
          // A flush wins over a miss. The refill is tried again next cycle.
          valid_d = '0;
        end else if (!hit) begin
          state_d      = S_REFILL;
          line_d       = imem_add_i[31:OFF_W];
          word_d       = '0;
          req_d        = 1'b1;
          flush_pend_d = 1'b0;
          if (miss_cnt_q != {CNT_W{1'b1}}) begin
            miss_cnt_d = miss_cnt_q + CNT_W'(1);
          end
        end
      end

      S_REFILL: begin
        // The bus transaction is never aborted. A flush is remembered and
        // applied once the line has been filled.
        if (flush_i) begin
          flush_pend_d = 1'b1;
        end
        if (mem_ack_i) begin
          if (last_word) begin
            state_d      = S_IDLE;
            req_d        = 1'b0;
            flush_pend_d = 1'b0;
            if (flush_pend_q || flush_i) begin
              valid_d = '0;
            end else begin
              valid_d[fill_idx] = 1'b1;
            end
          end else begin
            word_d = word_q + WORD_W'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples the values from before the edge.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      line_q       <= '0;
      word_q       <= '0;
      flush_pend_q <= 1'b0;
      req_q        <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      line_q       <= line_d;
      word_q       <= word_d;
      flush_pend_q <= flush_pend_d;
      req_q        <= req_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  // NOTE: the tag and data arrays have no reset. The valid bits decide what
  // is readable, so the arrays can map onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (data_we) begin
      data_mem[{fill_idx, word_q}] <= mem_data_i;
    end
    if (tag_we) begin
      tag_mem[fill_idx] <= fill_tag;
    end
  end

endmodule

// File: tb/tb_rv32i_icache.sv
// ---------------------------------------------------------------------------
// tb_rv32i_icache
//   Directed bench for rv32i_icache with default parameters. The memory
//   responder acks each request two cycles after the request appears. It
//   returns a fixed function of the address, so cached data is predictable.
//   The reference model tracks which line address each index holds and
//   whether a refill is outstanding. It is checked against the DUT on every
//   falling edge.
// ---------------------------------------------------------------------------
module tb_rv32i_icache;

  localparam int LW      = 4;
  localparam int NL      = 16;
  localparam int ACK_DLY = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic [31:0] addr = 32'h0;
  logic        flush = 1'b0;
  logic        resp_ack = 1'b0;
  logic        stray_ack = 1'b0;
  logic        ack;
  logic [31:0] mdata = 32'h0;

  logic [31:0] imem_data_o;
  logic        imem_valid_o;
  logic        mem_req_o;
  logic [31:0] mem_add_o;
  logic [31:0] hit_cnt_o;
  logic [31:0] miss_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] addr_log[$];

  assign ack = resp_ack | stray_ack;

  always #5 clk = ~clk;

  rv32i_icache dut (
    .clk_i        (clk),
    .resetn_i     (resetn),
    .imem_add_i   (addr),
    .imem_data_o  (imem_data_o),
    .imem_valid_o (imem_valid_o),
    .flush_i      (flush),
    .mem_req_o    (mem_req_o),
    .mem_add_o    (mem_add_o),
    .mem_ack_i    (ack),
    .mem_data_i   (mdata),
    .hit_cnt_o    (hit_cnt_o),
    .miss_cnt_o   (miss_cnt_o)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {16'hDEAD, a[15:2], 2'b00};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_valid [NL];
  logic [31:0] m_line  [NL];
  bit          m_busy;
  logic [31:0] m_base;
  int          m_got;
  bit          m_fpend;
  int          m_hits;
  int          m_misses;

  function automatic int m_idx(input logic [31:0] a);
    return int'((a / (LW * 4)) % NL);
  endfunction

  function automatic logic [31:0] m_lbase(input logic [31:0] a);
    return a & ~(32'(LW * 4) - 32'd1);
  endfunction

  function automatic bit m_has(input logic [31:0] a);
    return m_valid[m_idx(a)] && (m_line[m_idx(a)] == m_lbase(a));
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
    m_busy   = 1'b0;
    m_base   = 32'h0;
    m_got    = 0;
    m_fpend  = 1'b0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  initial m_reset();

  // Compare on the falling edge, then advance the model over the next
  // rising edge using the inputs that are stable now.
  always @(negedge clk) begin
    if (!resetn) begin
      check("rst_valid", {31'h0, imem_valid_o}, 32'h0);
      check("rst_data", imem_data_o, 32'h0);
      check("rst_req", {31'h0, mem_req_o}, 32'h0);
      check("rst_add", mem_add_o, 32'h0);
      check("rst_hit_cnt", hit_cnt_o, 32'h0);
      check("rst_miss_cnt", miss_cnt_o, 32'h0);
      m_reset();
    end else begin
      bit exp_valid;
      exp_valid = !m_busy && !flush && m_has(addr);
      check("valid", {31'h0, imem_valid_o}, {31'h0, exp_valid});
      check("data", imem_data_o, exp_valid ? mem_fn(addr) : 32'h0);
      check("req", {31'h0, mem_req_o}, {31'h0, m_busy});
      if (m_busy) check("mem_add", mem_add_o, m_base + 32'(4 * m_got));
      check("hit_cnt", hit_cnt_o, 32'(m_hits));
      check("miss_cnt", miss_cnt_o, 32'(m_misses));

      if (exp_valid) m_hits++;
      if (!m_busy) begin
        if (flush) begin
          for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
        end else if (!m_has(addr)) begin
          m_busy  = 1'b1;
          m_base  = m_lbase(addr);
          m_got   = 0;
          m_fpend = 1'b0;
          m_misses++;
        end
      end else begin
        if (flush) m_fpend = 1'b1;
        if (ack) begin
          m_got++;
          if (m_got == LW) begin
            m_busy = 1'b0;
            if (m_fpend) begin
              for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
            end else begin
              m_valid[m_idx(m_base)] = 1'b1;
              m_line[m_idx(m_base)]  = m_base;
            end
          end
        end
      end
    end
  end

  // ---------------- memory responder ----------------
  initial begin : responder
    int wcnt;
    wcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!resetn || !mem_req_o) begin
        resp_ack = 1'b0;
        wcnt     = 0;
      end else if (resp_ack) begin
        resp_ack = 1'b0;
        wcnt     = 1;
      end else begin
        wcnt++;
        if (wcnt == ACK_DLY + 1) begin
          resp_ack = 1'b1;
          mdata    = mem_fn(mem_add_o);
          addr_log.push_back(mem_add_o);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input logic level, input int budget);
    int n;
    n = 0;
    while (mem_req_o !== level && n < budget) begin
      cyc();
      n++;
    end
    if (mem_req_o !== level) check("timeout_req", {31'h0, mem_req_o}, {31'h0, level});
  endtask

  task automatic refill_line();
    wait_req(1'b1, 20);
    wait_req(1'b0, 100);
  endtask

  task automatic check_log(input string name, input logic [31:0] base);
    check({name, "_len"}, 32'(addr_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++)
      check(name, addr_log[i], base + 32'(4 * i));
  endtask

  // ---------------- directed tests ----------------
  initial begin : stim
    #2 resetn = 1'b0;
    repeat (3) cyc();
    check("t0_req", {31'h0, mem_req_o}, 32'h0);
    check("t0_add", mem_add_o, 32'h0);
    check("t0_valid", {31'h0, imem_valid_o}, 32'h0);

    // 1: cold miss on 0x104
    resetn = 1'b1;
    addr   = 32'h104;
    addr_log.delete();
    #1 check("t1_cold_valid", {31'h0, imem_valid_o}, 32'h0);
    wait_req(1'b1, 20);
    check("t1_first_add", mem_add_o, 32'h100);
    check("t1_miss_cnt_start", miss_cnt_o, 32'd1);
    wait_req(1'b0, 100);
    check("t1_hit_after_fill", {31'h0, imem_valid_o}, 32'h1);
    check("t1_data", imem_data_o, 32'hDEAD0104);
    check("t1_miss_cnt", miss_cnt_o, 32'd1);
    check_log("t1_refill_add", 32'h100);

    // 2: sweep the freshly filled line
    for (int i = 0; i < 4; i++) begin
      addr = 32'h100 + 32'(4 * i);
      #1;
      check("t2_valid", {31'h0, imem_valid_o}, 32'h1);
      check("t2_req", {31'h0, mem_req_o}, 32'h0);
      cyc();
    end
    check("t2_hit_cnt", hit_cnt_o, 32'd4);

    // an ack with no request outstanding is ignored
    stray_ack = 1'b1;
    cyc();
    stray_ack = 1'b0;
    check("t2_stray_req", {31'h0, mem_req_o}, 32'h0);
    check("t2_stray_miss_cnt", miss_cnt_o, 32'd1);

    // 3: conflict on index 0, from a fresh reset
    resetn = 1'b0;
    cyc();
    cyc();
    resetn = 1'b1;
    addr   = 32'h000;
    refill_line();
    check("t3_hit_000", {31'h0, imem_valid_o}, 32'h1);
    addr = 32'h100;
    #1 check("t3_miss_100", {31'h0, imem_valid_o}, 32'h0);
    refill_line();
    check("t3_hit_100", {31'h0, imem_valid_o}, 32'h1);
    addr = 32'h000;
    #1 check("t3_remiss_000", {31'h0, imem_valid_o}, 32'h0);
    wait_req(1'b1, 20);
    check("t3_miss_cnt", miss_cnt_o, 32'd3);
    wait_req(1'b0, 100);

    // 4: address changes during a refill
    addr_log.delete();
    addr = 32'h200;
    wait_req(1'b1, 20);
    repeat (4) cyc();
    addr = 32'h300;
    wait_req(1'b0, 100);
    check_log("t4_refill_add", 32'h200);
    check("t4_valid_300", {31'h0, imem_valid_o}, 32'h0);
    cyc();
    check("t4_req_300", {31'h0, mem_req_o}, 32'h1);
    check("t4_add_300", mem_add_o, 32'h300);
    wait_req(1'b0, 100);
    check("t4_hit_300", {31'h0, imem_valid_o}, 32'h1);
    check("t4_data_300", imem_data_o, 32'hDEAD0300);

    // 5a: flush while idle
    addr = 32'h104;
    refill_line();
    check("t5_hit_104", {31'h0, imem_valid_o}, 32'h1);
    flush = 1'b1;
    #1 check("t5_flush_masks", {31'h0, imem_valid_o}, 32'h0);
    cyc();
    flush = 1'b0;
    check("t5_no_refill", {31'h0, mem_req_o}, 32'h0);
    #1 check("t5_miss_104", {31'h0, imem_valid_o}, 32'h0);
    refill_line();
    check("t5_hit_104_again", {31'h0, imem_valid_o}, 32'h1);

    // 5b: flush during a refill
    addr = 32'h140;
    wait_req(1'b1, 20);
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    check("t5_refill_continues", {31'h0, mem_req_o}, 32'h1);
    wait_req(1'b0, 100);
    check("t5_miss_140", {31'h0, imem_valid_o}, 32'h0);
    addr = 32'h104;
    #1 check("t5_miss_104_cleared", {31'h0, imem_valid_o}, 32'h0);
    refill_line();

    // 6: reset in the middle of a refill
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    addr  = 32'h100;
    wait_req(1'b1, 20);
    begin
      int n;
      n = 0;
      while (mem_add_o !== 32'h104 && n < 20) begin
        cyc();
        n++;
      end
    end
    check("t6_second_word", mem_add_o, 32'h104);
    resetn = 1'b0;
    #1;
    check("t6_req_drop", {31'h0, mem_req_o}, 32'h0);
    check("t6_add_zero", mem_add_o, 32'h0);
    check("t6_miss_cnt_zero", miss_cnt_o, 32'h0);
    cyc();
    cyc();
    resetn = 1'b1;
    #1 check("t6_miss_after_rst", {31'h0, imem_valid_o}, 32'h0);
    refill_line();
    check("t6_hit_100", {31'h0, imem_valid_o}, 32'h1);
    check("t6_data_100", imem_data_o, 32'hDEAD0100);
    check("t6_miss_cnt", miss_cnt_o, 32'd1);

    repeat (3) cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
